posit_sum_serializer_es3: RTL and testbench
===========================================

POSIT_SUM_SERIALIZER_ES3 -- requirements
Module: posit_sum_serializer_es3

Interface
REQ-001 SHALL have parameter ABITS, default 30, fraction width of the sum value (FBITS+4).
REQ-002 SHALL have parameter WBITS, default 32, output word width.
REQ-003 SHALL have port clk  input  1  single clock for all state, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input value present.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_sgn  input  1  sign.
REQ-008 SHALL have port in_scale  input  9  signed scale.
REQ-009 SHALL have port in_fraction  input  ABITS  fraction.
REQ-010 SHALL have port in_inf  input  1  infinity/NaR flag.
REQ-011 SHALL have port in_zero  input  1  zero flag.
REQ-012 SHALL have port out_valid  output  1  output word present.
REQ-013 SHALL have port out_ready  input  1  sink accepts word.
REQ-014 SHALL have port out_data  output  WBITS  serialized word.
REQ-015 SHALL have port out_last  output  1  final word of a value.
REQ-016 SHALL have port pkt_count  output  16  values fully emitted, mod 2^16.

Function
REQ-017 SHALL form a 42-bit image S at capture: S[41]=sgn, S[40:32]=scale, S[31:2]=fraction, S[1]=inf, S[0]=zero.
REQ-018 SHALL canonicalize at capture: zero=1 and inf=0 -> sgn, scale, fraction stored as 0; inf=1 -> sgn, scale, fraction stored as 0, zero stored as 0 (inf dominates when both set).
REQ-019 SHALL implement FSM IDLE, BEAT0, BEAT1; reset state IDLE.
REQ-020 SHALL assert in_ready in IDLE, and in BEAT1 when out_ready=1; deassert otherwise.
REQ-021 SHALL capture S into the holding register when in_valid and in_ready are both 1, and enter BEAT0 next cycle.
REQ-022 SHALL in BEAT0 drive out_valid=1, out_data=S[31:0], out_last=0; out_valid&out_ready -> BEAT1.
REQ-023 SHALL in BEAT1 drive out_valid=1, out_data={22'b0,S[41:32]}, out_last=1.
REQ-024 SHALL on BEAT1 handshake increment pkt_count (0xFFFF wraps to 0x0000), then go to BEAT0 if a new value is captured in the same cycle, else IDLE.
REQ-025 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-026 SHALL drive out_valid=0, out_last=0, out_data=0 in IDLE.
REQ-027 SHALL have latency one cycle capture-to-first-word; back-to-back sustained throughput one value per two cycles with out_ready=1.
REQ-028 SHALL ignore in_* fields when in_ready=0; no value is dropped or duplicated.

Reset
REQ-029 SHALL on rst=1, independent of clk, force state IDLE, holding register 0, pkt_count 0, out_valid 0, out_last 0, out_data 0, in_ready 0 while rst is high.
REQ-030 SHALL discard any partially emitted value when reset is asserted mid-operation; pkt_count not incremented for it.
REQ-031 SHALL resume with in_ready=1 on the first clk edge after rst deasserts.

Verification
REQ-032 SHALL cover normal value: sgn=1, scale=9'h1F5, fraction=30'h2AAAAAAA, inf=0, zero=0, out_ready=1 -> words 0xAAAAAAA8 (last=0), 0x000003F5 (last=1), pkt_count=1.
REQ-033 SHALL cover zero: sgn=1, scale=9'h010, fraction=30'h1, zero=1 -> 0x00000001, 0x00000000; inf and zero both 1 with sgn=1 -> 0x00000002, 0x00000000.
REQ-034 SHALL cover backpressure: out_ready=0 for 5 cycles in BEAT0 -> out_data=0xAAAAAAA8 stable, in_ready=0, no count change.
REQ-035 SHALL cover back-to-back: 3 values, in_valid and out_ready held 1 -> 6 words in 6 consecutive cycles, pkt_count=3.
REQ-036 SHALL cover wrap and reset: preload 65535 values -> pkt_count=0xFFFF, next value -> 0x0000; rst pulsed during BEAT1 -> out_valid=0 immediately, pkt_count=0.

Source files
------------

// File: rtl/posit_sum_serializer_es3.sv
// Posit sum serializer (es=3): captures one decoded sum value (sign, scale,
// fraction, inf/zero flags), canonicalizes it, and emits it as two words:
// the low word carries fraction and flags, the high word carries sign and scale.
module posit_sum_serializer_es3 #(
  parameter int ABITS = 30,
  parameter int WBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sgn,
  input  logic [8:0]       in_scale,
  input  logic [ABITS-1:0] in_fraction,
  input  logic             in_inf,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WBITS-1:0] out_data,
  output logic             out_last,
  output logic [15:0]      pkt_count
);

  // Image layout: {sgn, scale[8:0], fraction, inf, zero}
  localparam int SBITS = ABITS + 12;
  // Bits above the low 32-bit word go to the second beat
  localparam int HBITS = SBITS - 32;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [SBITS-1:0]   hold_reg;
  logic [SBITS-1:0]   img_next;
  logic [15:0]        pkt_count_reg;
  logic               armed_reg;
  logic [WBITS-1:0]   lo_word;
  logic [WBITS-1:0]   hi_word;
  logic               capture;
  logic               done;

  // Canonical image: inf wins over zero, and either flag clears the payload
  always_comb begin
    img_next = '0;
    if (in_inf) begin
      img_next[1] = 1'b1;
    end else if (in_zero) begin
      img_next[0] = 1'b1;
    end else begin
      img_next = {in_sgn, in_scale, in_fraction, 2'b00};
    end
  end

  // Word images, zero-extended to the output width
  genvar gi;
  generate
    for (gi = 0; gi < WBITS; gi++) begin : g_words
      if (gi < 32) begin : g_lo
        assign lo_word[gi] = hold_reg[gi];
      end else begin : g_lo_pad
        assign lo_word[gi] = 1'b0;
      end
      if (gi < HBITS) begin : g_hi
        assign hi_word[gi] = hold_reg[32+gi];
      end else begin : g_hi_pad
        assign hi_word[gi] = 1'b0;
      end
    end
  endgenerate

  // Next state and handshake/output decode
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        // armed_reg keeps in_ready low until the first edge after reset
        in_ready = armed_reg;
        if (in_valid && armed_reg) begin
          state_next = BEAT0;
        end
      end
      BEAT0: begin
        out_valid = 1'b1;
        out_data  = lo_word;
        if (out_ready) begin
          state_next = BEAT1;
        end
      end
      BEAT1: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = hi_word;
        // A new value may be taken in the same cycle the last word leaves
        in_ready  = out_ready;
        if (out_ready) begin
          done       = 1'b1;
          state_next = in_valid ? BEAT0 : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign capture   = in_valid && in_ready;
  assign pkt_count = pkt_count_reg;

  // State register and the post-reset arming flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
    end
  end

  // Holding register: loaded only on an accepted input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg <= '0;
    end else if (capture) begin
      hold_reg <= img_next;
    end
  end

  // Completed-value counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count_reg <= '0;
    end else if (done) begin
      pkt_count_reg <= pkt_count_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_posit_sum_serializer_es3.sv
// Testbench for posit_sum_serializer_es3: directed cases plus random traffic,
// checked every cycle against a queue-based model of the emitted words.
module tb_posit_sum_serializer_es3;

  localparam int ABITS = 30;
  localparam int WBITS = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_sgn = 1'b0;
  logic [8:0]       in_scale = '0;
  logic [ABITS-1:0] in_fraction = '0;
  logic             in_inf = 1'b0;
  logic             in_zero = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WBITS-1:0] out_data;
  logic             out_last;
  logic [15:0]      pkt_count;

  posit_sum_serializer_es3 #(.ABITS(ABITS), .WBITS(WBITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sgn(in_sgn), .in_scale(in_scale), .in_fraction(in_fraction),
    .in_inf(in_inf), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          hs = 0;
  logic [32:0] exp_q[$];   // {last, word} still owed by the DUT
  logic [32:0] obs_q[$];   // {last, word} seen on output handshakes
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Stored image of a value: flags clear the payload, inf wins over zero
  function automatic logic [41:0] img(input logic s, input logic [8:0] sc,
                                      input logic [29:0] fr, input logic inf,
                                      input logic z);
    logic [41:0] r;
    r = {s, sc, fr, inf, z};
    if (inf) r = 42'd2;
    else if (z) r = 42'd1;
    return r;
  endfunction

  // One clock: drive inputs, check at negedge, update the model, advance
  task automatic step(input logic v, input logic s, input logic [8:0] sc,
                      input logic [29:0] fr, input logic inf, input logic z,
                      input logic ordy, output logic acc);
    logic        exp_rdy;
    logic [32:0] front;
    logic [41:0] sv;
    in_valid = v; in_sgn = s; in_scale = sc; in_fraction = fr;
    in_inf = inf; in_zero = z; out_ready = ordy;
    @(negedge clk);
    exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      front = exp_q[0];
      chk("out_data", out_data, front[31:0]);
      chk("out_last", out_last, front[32]);
    end else begin
      chk("idle_data", out_data, 0);
      chk("idle_last", out_last, 0);
    end
    chk("pkt_count", pkt_count, exp_cnt);
    if (exp_q.size() != 0 && ordy) begin
      obs_q.push_back({out_last, out_data});
      hs++;
      front = exp_q.pop_front();
      if (front[32]) exp_cnt = exp_cnt + 16'd1;
    end
    acc = v && exp_rdy;
    if (acc) begin
      sv = img(s, sc, fr, inf, z);
      exp_q.push_back({1'b0, sv[31:0]});
      exp_q.push_back({1'b1, 22'd0, sv[41:32]});
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step(1'b0, 1'b0, 9'd0, 30'd0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  task automatic send(input logic s, input logic [8:0] sc, input logic [29:0] fr,
                      input logic inf, input logic z);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 10) begin
      step(1'b1, s, sc, fr, inf, z, 1'b1, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic        acc;
    logic [15:0] c0;
    int          hs0;
    int          idx;
    logic [29:0] fr_v[3];
    logic [8:0]  sc_v[3];

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pkt_count", pkt_count, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("resume_in_ready", in_ready, 1);

    // Normal value
    obs_q.delete();
    send(1'b1, 9'h1F5, 30'h2AAAAAAA, 1'b0, 1'b0);
    chk("normal_w0", obs_q[0], {1'b0, 32'hAAAAAAA8});
    chk("normal_w1", obs_q[1], {1'b1, 32'h000003F5});
    chk("normal_cnt", pkt_count, 1);

    // Zero, then inf together with zero
    obs_q.delete();
    send(1'b1, 9'h010, 30'h1, 1'b0, 1'b1);
    send(1'b1, 9'h010, 30'h1, 1'b1, 1'b1);
    chk("zero_w0", obs_q[0], {1'b0, 32'h00000001});
    chk("zero_w1", obs_q[1], {1'b1, 32'h00000000});
    chk("inf_w0", obs_q[2], {1'b0, 32'h00000002});
    chk("inf_w1", obs_q[3], {1'b1, 32'h00000000});

    // Backpressure in the first beat; offered inputs must be ignored
    c0 = pkt_count;
    step(1'b1, 1'b1, 9'h1F5, 30'h2AAAAAAA, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_accept", acc, 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 9'h0AA, 30'h155, 1'b0, 1'b0, 1'b0, acc);
      chk("bp_data", out_data, 32'hAAAAAAA8);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_cnt", pkt_count, c0);
    end
    drain();

    // Back-to-back: three values, six words in six consecutive cycles
    for (int i = 0; i < 3; i++) begin
      fr_v[i] = 30'($urandom);
      sc_v[i] = 9'($urandom);
    end
    hs0 = hs;
    c0 = pkt_count;
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      step(idx < 3, 1'($urandom), sc_v[idx % 3], fr_v[idx % 3], 1'b0, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("b2b_words", hs - hs0, 6);
    chk("b2b_cnt", pkt_count, c0 + 16'd3);

    // Random traffic with random backpressure and flags
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 1'($urandom), 9'($urandom), 30'($urandom),
           ($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0, acc);
    end
    drain();

    // Counter wrap from a preloaded value
    force dut.pkt_count_reg = 16'hFFFE;
    #1;
    release dut.pkt_count_reg;
    exp_cnt = 16'hFFFE;
    @(posedge clk); #1;
    send(1'b0, 9'h001, 30'h3, 1'b0, 1'b0);
    chk("wrap_ffff", pkt_count, 16'hFFFF);
    send(1'b0, 9'h002, 30'h4, 1'b0, 1'b0);
    chk("wrap_0000", pkt_count, 16'h0000);

    // Reset while the last word is pending
    send(1'b0, 9'h003, 30'h5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 9'h1F5, 30'h2AAAAAAA, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, 1'b0, 9'h0, 30'h0, 1'b0, 1'b0, 1'b1, acc);
    chk("pre_rst_last", out_last, 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_cnt", pkt_count, 0);
    exp_q.delete();
    exp_cnt = 16'd0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);
    obs_q.delete();
    send(1'b0, 9'h07F, 30'h0000FFFF, 1'b0, 1'b0);
    chk("post_rst_w0", obs_q[0], {1'b0, 32'h0003FFFC});
    chk("post_rst_w1", obs_q[1], {1'b1, 32'h0000007F});
    chk("post_rst_cnt", pkt_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
